// File: rtl/spi_ram_slave_if.sv
// Command/response bundle between the SPI slave front-end and the RAM behind it.
// The slave modport is the RAM side. The master modport is the SPI side or a bench.
interface spi_ram_slave_if #(
  parameter int ADDR_SIZE = 8
);
  logic [ADDR_SIZE+1:0] din;
  logic                 rx_valid;
  logic [7:0]           dout;
  logic                 tx_valid;
  logic                 err;

  modport slave (
    input  din,
    input  rx_valid,
    output dout,
    output tx_valid,
    output err
  );

  modport master (
    output din,
    output rx_valid,
    input  dout,
    input  tx_valid,
    input  err
  );
endinterface

// File: rtl/spi_ram_slave.sv
// Command-decoding byte RAM behind the SPI slave. Read data and err appear 1 clk after the command.
// There is no backpressure: each cycle with rx_valid high executes one command.
module spi_ram_slave #(
  parameter int MEM_DEPTH = 256,
  parameter int ADDR_SIZE = 8
) (
  input logic            clk,
  input logic            rst_n,
  spi_ram_slave_if.slave bus
);

  typedef enum logic [1:0] {
    CMD_WR_ADDR = 2'b00,
    CMD_WR_DATA = 2'b01,
    CMD_RD_ADDR = 2'b10,
    CMD_RD_DATA = 2'b11
  } cmd_e;

  logic [7:0]           mem [MEM_DEPTH];

  logic [ADDR_SIZE-1:0] wr_addr_q, wr_addr_d;
  logic [ADDR_SIZE-1:0] rd_addr_q, rd_addr_d;
  logic                 wr_addr_ok_q, wr_addr_ok_d;
  logic                 rd_addr_ok_q, rd_addr_ok_d;
  logic [7:0]           dout_q, dout_d;
  logic                 tx_valid_q, tx_valid_d;
  logic                 err_q, err_d;
  logic                 mem_we;
  logic                 wr_in_range, rd_in_range;
  cmd_e                 cmd;

  assign cmd = cmd_e'(bus.din[ADDR_SIZE+1:ADDR_SIZE]);

  // A full-size array has no out-of-range addresses, so skip the compare entirely.
  if (MEM_DEPTH >= (1 << ADDR_SIZE)) begin : g_full
    assign wr_in_range = 1'b1;
    assign rd_in_range = 1'b1;
  end else begin : g_part
    localparam logic [ADDR_SIZE-1:0] DEPTH_L = ADDR_SIZE'(MEM_DEPTH);
    assign wr_in_range = (wr_addr_q < DEPTH_L);
    assign rd_in_range = (rd_addr_q < DEPTH_L);
  end

  always_comb begin
    wr_addr_d    = wr_addr_q;
    rd_addr_d    = rd_addr_q;
    wr_addr_ok_d = wr_addr_ok_q;
    rd_addr_ok_d = rd_addr_ok_q;
    dout_d       = dout_q;
    tx_valid_d   = 1'b0;
    err_d        = 1'b0;
    mem_we       = 1'b0;
    if (bus.rx_valid) begin
      unique case (cmd)
        CMD_WR_ADDR: begin
          wr_addr_d    = bus.din[ADDR_SIZE-1:0];
          wr_addr_ok_d = 1'b1;
        end
        CMD_WR_DATA: begin
          if (wr_addr_ok_q && wr_in_range) mem_we = 1'b1;
          else                             err_d  = 1'b1;
        end
        CMD_RD_ADDR: begin
          rd_addr_d    = bus.din[ADDR_SIZE-1:0];
          rd_addr_ok_d = 1'b1;
        end
        CMD_RD_DATA: begin
          if (rd_addr_ok_q && rd_in_range) begin
            dout_d     = mem[rd_addr_q];
            tx_valid_d = 1'b1;
          end else begin
            dout_d = 8'h00;
            err_d  = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_addr_q    <= '0;
      rd_addr_q    <= '0;
      wr_addr_ok_q <= 1'b0;
      rd_addr_ok_q <= 1'b0;
      dout_q       <= 8'h00;
      tx_valid_q   <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      wr_addr_q    <= wr_addr_d;
      rd_addr_q    <= rd_addr_d;
      wr_addr_ok_q <= wr_addr_ok_d;
      rd_addr_ok_q <= rd_addr_ok_d;
      dout_q       <= dout_d;
      tx_valid_q   <= tx_valid_d;
      err_q        <= err_d;
    end
  end

  // Array contents survive reset; only the address/flag state is cleared.
  always_ff @(posedge clk) begin
    if (mem_we) mem[wr_addr_q] <= bus.din[7:0];
  end

  assign bus.dout     = dout_q;
  assign bus.tx_valid = tx_valid_q;
  assign bus.err      = err_q;

endmodule

// File: tb/tb_spi_ram_slave.sv
// Directed bench for spi_ram_slave: inputs are driven on falling edges.
// Outputs are sampled on the next falling edge, after the rising edge that executes the command.
module tb_spi_ram_slave;
  logic clk;
  logic rst_n;
  int   checks;
  int   errors;
  int   pulses;
  int   errs_seen;

  spi_ram_slave_if #(.ADDR_SIZE(8)) bus ();

  spi_ram_slave #(.MEM_DEPTH(256), .ADDR_SIZE(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Executes one command and returns on the falling edge after the executing rising edge.
  task automatic send(input logic [9:0] w);
    @(negedge clk);
    bus.din      = w;
    bus.rx_valid = 1'b1;
    @(negedge clk);
    bus.rx_valid = 1'b0;
    bus.din      = 'x;
  endtask

  initial begin
    logic [7:0] e;
    logic [7:0] a;
    checks = 0;
    errors = 0;
    rst_n        = 1'b0;
    bus.din      = '0;
    bus.rx_valid = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_dout", 32'(bus.dout), 0);
    chk("rst_tx_valid", 32'(bus.tx_valid), 0);
    chk("rst_err", 32'(bus.err), 0);
    rst_n = 1'b1;

    // 1: write A5 to address 5
    send(10'b00_0000_0101);
    chk("t1_wa_tx", 32'(bus.tx_valid), 0);
    chk("t1_wa_err", 32'(bus.err), 0);
    send(10'b01_1010_0101);
    chk("t1_wd_tx", 32'(bus.tx_valid), 0);
    chk("t1_wd_err", 32'(bus.err), 0);

    // 2: read it back
    send(10'b10_0000_0101);
    chk("t2_ra_tx", 32'(bus.tx_valid), 0);
    send(10'b11_0000_0000);
    chk("t2_rd_tx", 32'(bus.tx_valid), 1);
    chk("t2_rd_dout", 32'(bus.dout), 32'h A5);
    chk("t2_rd_err", 32'(bus.err), 0);
    @(negedge clk);
    chk("t2_tx_drop", 32'(bus.tx_valid), 0);
    chk("t2_dout_hold", 32'(bus.dout), 32'h A5);

    // X on din with rx_valid low changes nothing
    bus.din = 'x;
    repeat (2) @(negedge clk);
    chk("x_idle_tx", 32'(bus.tx_valid), 0);
    chk("x_idle_err", 32'(bus.err), 0);
    chk("x_idle_dout", 32'(bus.dout), 32'h A5);

    // 3: full sweep, mem[i] = ~i
    errs_seen = 0;
    for (int i = 0; i < 256; i++) begin
      a = i[7:0];
      send({2'b00, a});
      errs_seen += int'(bus.err);
      send({2'b01, ~a});
      errs_seen += int'(bus.err);
    end
    chk("t3_wr_errs", 32'(errs_seen), 0);
    pulses = 0;
    for (int i = 0; i < 256; i++) begin
      a = i[7:0];
      e = ~a;
      send({2'b10, a});
      pulses += int'(bus.tx_valid);
      send({2'b11, 8'h5A});
      pulses += int'(bus.tx_valid);
      if (bus.dout !== e || bus.tx_valid !== 1'b1) begin
        chk($sformatf("t3_rd_%0d", i), {23'd0, bus.tx_valid, bus.dout}, {23'd0, 1'b1, e});
      end
    end
    chk("t3_pulses", 32'(pulses), 256);
    chk("t3_last_dout", 32'(bus.dout), 32'h00);

    // 4: commands without a fresh address after reset are rejected
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    send(10'b01_0011_1100);
    chk("t4_wd_err", 32'(bus.err), 1);
    chk("t4_wd_tx", 32'(bus.tx_valid), 0);
    @(negedge clk);
    chk("t4_err_drop", 32'(bus.err), 0);
    send(10'b11_0000_0000);
    chk("t4_rd_err", 32'(bus.err), 1);
    chk("t4_rd_tx", 32'(bus.tx_valid), 0);
    chk("t4_rd_dout", 32'(bus.dout), 0);
    send(10'b10_0000_0000);
    send(10'b11_0000_0000);
    chk("t4_mem0_kept", 32'(bus.dout), 32'h FF);
    chk("t4_mem0_tx", 32'(bus.tx_valid), 1);

    // write then read on consecutive commands
    send(10'b00_0000_0111);
    send(10'b01_0101_1010);
    send(10'b10_0000_0111);
    send(10'b11_1111_1111);
    chk("wr_rd_b2b", 32'(bus.dout), 32'h 5A);

    // 5: rx_valid held for three read-data cycles
    send(10'b10_0000_0101);
    @(negedge clk);
    bus.din      = 10'b11_0000_0000;
    bus.rx_valid = 1'b1;
    pulses = 0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      pulses += int'(bus.tx_valid);
      chk($sformatf("t5_dout_%0d", k), 32'(bus.dout), 32'h FA);
    end
    bus.rx_valid = 1'b0;
    chk("t5_pulses", 32'(pulses), 3);
    @(negedge clk);
    chk("t5_tx_drop", 32'(bus.tx_valid), 0);

    // 6: reset lands in the cycle tx_valid is high
    @(negedge clk);
    bus.din      = 10'b11_0000_0000;
    bus.rx_valid = 1'b1;
    @(posedge clk);
    #2;
    chk("t6_pre_tx", 32'(bus.tx_valid), 1);
    rst_n = 1'b0;
    #1;
    chk("t6_rst_tx", 32'(bus.tx_valid), 0);
    chk("t6_rst_dout", 32'(bus.dout), 0);
    chk("t6_rst_err", 32'(bus.err), 0);
    bus.rx_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    send(10'b11_0000_0000);
    chk("t6_rd_err", 32'(bus.err), 1);
    chk("t6_rd_tx", 32'(bus.tx_valid), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
